nf_mem_arb: RTL and testbench

//  Shares one memory bus between the CPU instruction-fetch port and data port (unified-memory build).
//  - Serializes requests and drives req_ack_i / req_ack_dm, which the hazard unit uses to stall/flush.
//  - Data port has priority; a fairness counter bounds instruction starvation.
//  - Bus timeout completes a hung access with rd=0 and an error pulse.

---
 rtl/nf_mem_arb_pkg.sv | 19 +
 rtl/nf_mem_arb.sv | 158 +++++++++++++++
 tb/tb_nf_mem_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf_mem_arb_pkg.sv
// Shared types and defaults for the unified-memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nf_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUS_I = 2'd1,
        ARB_BUS_D = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    // Instruction fetches are always full words.
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int DEF_D_BURST_MAX = 4;
    localparam int DEF_TO_W        = 8;

endpackage

// File: rtl/nf_mem_arb.sv
// Arbitrates the instruction-fetch and data ports onto one memory bus, data first with bounded instr starvation.
// Latency: request seen in IDLE cycle N, bus ack in cycle M >= N+1, port ack in cycle M+1 (3 cycles minimum).
// Backpressure: ports hold req until their one-cycle ack; a silent bus is cut off by a timeout that acks with bus_err.
module nf_mem_arb
    import nf_mem_arb_pkg::*;
#(
    parameter int D_BURST_MAX = DEF_D_BURST_MAX,
    parameter int TO_W        = DEF_TO_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        req_i,
    output logic [31:0] rd_i,
    output logic        req_ack_i,
    input  logic [31:0] addr_dm,
    input  logic [31:0] wd_dm,
    input  logic        we_dm,
    input  logic [1:0]  size_dm,
    input  logic        req_dm,
    output logic [31:0] rd_dm,
    output logic        req_ack_dm,
    output logic [31:0] addr_bus,
    output logic [31:0] wd_bus,
    output logic        we_bus,
    output logic [1:0]  size_bus,
    output logic        req_bus,
    input  logic [31:0] rd_bus,
    input  logic        req_ack_bus,
    output logic        bus_err
);

    localparam int              DCW     = $clog2(D_BURST_MAX + 1);
    localparam logic [DCW-1:0]  D_LIMIT = DCW'(D_BURST_MAX);
    // The access is abandoned in the bus cycle whose increment would bring
    // to_cnt to 2**TO_W-1, so req_bus stays up for exactly 2**TO_W-1 cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((2 ** TO_W) - 2);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic            owner_d;   // 1 = current access belongs to the data port
    logic            err_flag;  // current access ended by timeout
    logic [DCW-1:0]  d_cnt;     // consecutive data grants while instr waits
    logic [TO_W-1:0] to_cnt;
    logic            grant_i;
    logic            grant_d;
    logic            bus_ok;
    logic            bus_to;
    logic            in_bus;

    assign in_bus = (state == ARB_BUS_I) || (state == ARB_BUS_D);

    // Next-state and grant decision; the bus ack takes precedence over a coincident timeout.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        bus_ok    = 1'b0;
        bus_to    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (req_dm && !(req_i && (d_cnt == D_LIMIT))) begin
                    grant_d   = 1'b1;
                    state_nxt = ARB_BUS_D;
                end else if (req_i) begin
                    grant_i   = 1'b1;
                    state_nxt = ARB_BUS_I;
                end
            end
            ARB_BUS_I, ARB_BUS_D: begin
                if (req_ack_bus) begin
                    bus_ok    = 1'b1;
                    state_nxt = ARB_RESP;
                end else if (to_cnt == TO_LAST) begin
                    bus_to    = 1'b1;
                    state_nxt = ARB_RESP;
                end
            end
            // The pipeline still shows the just-served request here, so nothing is sampled.
            ARB_RESP: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // State, ownership, fairness/timeout counters and the registered bus request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            owner_d  <= 1'b0;
            err_flag <= 1'b0;
            d_cnt    <= '0;
            to_cnt   <= '0;
            addr_bus <= '0;
            wd_bus   <= '0;
            we_bus   <= 1'b0;
            size_bus <= '0;
            req_bus  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                owner_d  <= 1'b1;
                err_flag <= 1'b0;
                to_cnt   <= '0;
                req_bus  <= 1'b1;
                addr_bus <= addr_dm;
                wd_bus   <= wd_dm;
                we_bus   <= we_dm;
                size_bus <= size_dm;
                // Only a waiting instr fetch makes a data grant count against fairness.
                d_cnt    <= req_i ? (d_cnt + DCW'(1)) : '0;
            end else if (grant_i) begin
                owner_d  <= 1'b0;
                err_flag <= 1'b0;
                to_cnt   <= '0;
                req_bus  <= 1'b1;
                addr_bus <= addr_i;
                wd_bus   <= '0;
                we_bus   <= 1'b0;
                size_bus <= SIZE_WORD;
                d_cnt    <= '0;
            end
            if (in_bus) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (bus_ok) begin
                req_bus <= 1'b0;
            end else if (bus_to) begin
                req_bus  <= 1'b0;
                err_flag <= 1'b1;
            end
        end
    end

    // Per-port read data: updated only when that port's access finishes, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_i  <= '0;
            rd_dm <= '0;
        end else if (bus_ok) begin
            if (owner_d) begin
                rd_dm <= we_bus ? 32'h0 : rd_bus;
            end else begin
                rd_i <= rd_bus;
            end
        end else if (bus_to) begin
            if (owner_d) begin
                rd_dm <= 32'h0;
            end else begin
                rd_i <= 32'h0;
            end
        end
    end

    assign req_ack_i  = (state == ARB_RESP) && !owner_d;
    assign req_ack_dm = (state == ARB_RESP) && owner_d;
    assign bus_err    = (state == ARB_RESP) && err_flag;

endmodule

// File: tb/tb_nf_mem_arb.sv
// Self-checking bench for nf_mem_arb with a scripted bus responder and per-port expectation queues.
// Runs with D_BURST_MAX=4 and TO_W=3 so the timeout fires after 7 bus cycles.
// Every wait is bounded; a global watchdog ends the run if anything stalls.
module tb_nf_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i;
    logic        req_i;
    logic [31:0] rd_i;
    logic        req_ack_i;
    logic [31:0] addr_dm;
    logic [31:0] wd_dm;
    logic        we_dm;
    logic [1:0]  size_dm;
    logic        req_dm;
    logic [31:0] rd_dm;
    logic        req_ack_dm;
    logic [31:0] addr_bus;
    logic [31:0] wd_bus;
    logic        we_bus;
    logic [1:0]  size_bus;
    logic        req_bus;
    logic [31:0] rd_bus;
    logic        req_ack_bus;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    bit bus_dead = 1'b0;
    int bus_lat  = 0;

    nf_mem_arb #(.D_BURST_MAX(4), .TO_W(3)) dut (
        .clk(clk), .rst(rst),
        .addr_i(addr_i), .req_i(req_i), .rd_i(rd_i), .req_ack_i(req_ack_i),
        .addr_dm(addr_dm), .wd_dm(wd_dm), .we_dm(we_dm), .size_dm(size_dm),
        .req_dm(req_dm), .rd_dm(rd_dm), .req_ack_dm(req_ack_dm),
        .addr_bus(addr_bus), .wd_bus(wd_bus), .we_bus(we_bus), .size_bus(size_bus),
        .req_bus(req_bus), .rd_bus(rd_bus), .req_ack_bus(req_ack_bus), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        if (a == 32'h0000_0200) return 32'h0000_1234;
        return {~a[15:0], a[15:0]};
    endfunction

    // Bus responder: acks in the (bus_lat+1)-th cycle req_bus is high, never when bus_dead.
    initial begin
        int hi;
        hi          = 0;
        req_ack_bus = 1'b0;
        rd_bus      = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (req_bus) begin
                hi = hi + 1;
                if (!bus_dead && hi == bus_lat + 1) begin
                    req_ack_bus = 1'b1;
                    rd_bus      = data_fn(addr_bus);
                end else begin
                    req_ack_bus = 1'b0;
                    rd_bus      = 32'hBAD0_BAD0;
                end
            end else begin
                hi          = 0;
                req_ack_bus = 1'b0;
                rd_bus      = 32'hBAD0_BAD0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; req_i = 1'b0; req_dm = 1'b0; addr_i = '0; addr_dm = '0;
        wd_dm = '0; we_dm = 1'b0; size_dm = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if ({req_bus, req_ack_i, req_ack_dm, bus_err, we_bus} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got req_bus/acks/err/we=%b want 00000",
                     {req_bus, req_ack_i, req_ack_dm, bus_err, we_bus});
        end
        total++;
        if ({rd_i, rd_dm, addr_bus, wd_bus, size_bus} !== 130'b0) begin
            bad++;
            $display("FAIL reset_data: rd_i=%h rd_dm=%h addr_bus=%h wd_bus=%h size=%b want all 0",
                     rd_i, rd_dm, addr_bus, wd_bus, size_bus);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (req_bus !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req: req_bus=%b want 0", req_bus);
        end
    endtask

    task automatic test_single_instr();
        logic [31:0] e;
        bus_lat = 0;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h100;
        exp_i.push_back(data_fn(32'h100));
        @(negedge clk);
        total++;
        if ({req_bus, we_bus, size_bus, req_ack_i} !== 5'b10100 || addr_bus !== 32'h100) begin
            bad++;
            $display("FAIL instr_issue: req_bus=%b we=%b size=%b ack=%b addr=%h want 1 0 10 0 00000100",
                     req_bus, we_bus, size_bus, req_ack_i, addr_bus);
        end
        @(negedge clk);
        e = (exp_i.size() > 0) ? exp_i.pop_front() : 32'hFFFF_FFFF;
        total++;
        if (req_ack_i !== 1'b1 || rd_i !== e || bus_err !== 1'b0 || req_ack_dm !== 1'b0) begin
            bad++;
            $display("FAIL instr_ack_3rd_cycle: ack_i=%b rd_i=%h err=%b ack_dm=%b want 1 %h 0 0",
                     req_ack_i, rd_i, bus_err, req_ack_dm, e);
        end
        req_i = 1'b0;
        @(negedge clk);
        total++;
        if (req_ack_i !== 1'b0 || rd_i !== e || req_bus !== 1'b0) begin
            bad++;
            $display("FAIL instr_ack_pulse: ack_i=%b rd_i=%h req_bus=%b want 0 %h 0",
                     req_ack_i, rd_i, req_bus, e);
        end
    endtask

    task automatic test_simultaneous();
        int ack_d_cyc, ack_i_cyc;
        logic [31:0] e;
        ack_d_cyc = -1; ack_i_cyc = -1;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h300;
        req_dm = 1'b1; addr_dm = 32'h400; wd_dm = 32'h55; we_dm = 1'b1; size_dm = 2'b10;
        exp_i.push_back(data_fn(32'h300));
        exp_d.push_back(32'h0);
        @(negedge clk);
        total++;
        if (req_bus !== 1'b1 || addr_bus !== 32'h400 || wd_bus !== 32'h55 || we_bus !== 1'b1) begin
            bad++;
            $display("FAIL data_first_issue: req_bus=%b addr=%h wd=%h we=%b want 1 00000400 00000055 1",
                     req_bus, addr_bus, wd_bus, we_bus);
        end
        for (int c = 1; c < 40 && (ack_d_cyc < 0 || ack_i_cyc < 0); c++) begin
            if (req_ack_i && req_ack_dm) begin
                total++; bad++;
                $display("FAIL dual_ack: both acks high in cycle %0d", c);
            end
            if (req_ack_dm) begin
                ack_d_cyc = c;
                e = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hFFFF_FFFF;
                total++;
                if (rd_dm !== e) begin
                    bad++;
                    $display("FAIL store_rd: rd_dm=%h want %h", rd_dm, e);
                end
                req_dm = 1'b0; we_dm = 1'b0;
            end
            if (req_ack_i) begin
                ack_i_cyc = c;
                e = (exp_i.size() > 0) ? exp_i.pop_front() : 32'hFFFF_FFFF;
                total++;
                if (rd_i !== e) begin
                    bad++;
                    $display("FAIL instr_after_data_rd: rd_i=%h want %h", rd_i, e);
                end
                req_i = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (ack_d_cyc < 0 || ack_i_cyc < 0 || ack_d_cyc >= ack_i_cyc) begin
            bad++;
            $display("FAIL sim_order: data ack cycle=%0d instr ack cycle=%0d want data earlier, both seen",
                     ack_d_cyc, ack_i_cyc);
        end
    endtask

    task automatic test_fairness();
        int n, da, ia;
        logic [31:0] e;
        n = 0; da = 1; ia = 1;
        req_i = 1'b1; addr_i = 32'h2000;
        req_dm = 1'b1; addr_dm = 32'h1000; we_dm = 1'b0; size_dm = 2'b10;
        exp_i.push_back(data_fn(32'h2000));
        exp_d.push_back(data_fn(32'h1000));
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (req_ack_i && req_ack_dm) begin
                total++; bad++;
                $display("FAIL dual_ack_burst: both acks high at grant %0d", n);
            end
            if (req_ack_dm) begin
                e = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hFFFF_FFFF;
                total++;
                if (rd_dm !== e || n % 5 == 4) begin
                    bad++;
                    $display("FAIL burst_data grant %0d: rd_dm=%h want %h, slot wants instr=%0d",
                             n, rd_dm, e, (n % 5 == 4));
                end
                n++;
                addr_dm = 32'h1000 + 32'(4 * da); da++;
                exp_d.push_back(data_fn(addr_dm));
            end else if (req_ack_i) begin
                e = (exp_i.size() > 0) ? exp_i.pop_front() : 32'hFFFF_FFFF;
                total++;
                if (rd_i !== e || n % 5 != 4) begin
                    bad++;
                    $display("FAIL burst_instr grant %0d: rd_i=%h want %h, slot wants instr=%0d",
                             n, rd_i, e, (n % 5 == 4));
                end
                n++;
                addr_i = 32'h2000 + 32'(4 * ia); ia++;
                exp_i.push_back(data_fn(addr_i));
            end
            if (n >= 10) begin
                // Withdraw in the ack cycle: the pending requests were never granted.
                req_i = 1'b0; req_dm = 1'b0;
                exp_i.delete(); exp_d.delete();
            end
        end
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL burst_timeout: saw %0d grants want 10", n);
        end
        repeat (4) @(negedge clk);
        total++;
        if (req_bus !== 1'b0 || req_ack_i !== 1'b0 || req_ack_dm !== 1'b0) begin
            bad++;
            $display("FAIL withdrawn_ignored: req_bus=%b ack_i=%b ack_dm=%b want 0 0 0",
                     req_bus, req_ack_i, req_ack_dm);
        end
    endtask

    task automatic test_timeout();
        int hi;
        bit seen;
        logic [31:0] e;
        hi = 0; seen = 1'b0;
        bus_dead = 1'b1;
        @(negedge clk);
        req_dm = 1'b1; addr_dm = 32'h500; we_dm = 1'b0; size_dm = 2'b10;
        exp_d.push_back(32'h0);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (req_bus) hi++;
            if (req_ack_dm) seen = 1'b1;
        end
        e = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hFFFF_FFFF;
        total++;
        if (!seen || hi != 7 || bus_err !== 1'b1 || rd_dm !== e) begin
            bad++;
            $display("FAIL timeout: ack=%0d req_bus cycles=%0d err=%b rd_dm=%h want 1 7 1 %h",
                     seen, hi, bus_err, rd_dm, e);
        end
        req_dm = 1'b0;
        bus_dead = 1'b0;
        @(negedge clk);
        total++;
        if (bus_err !== 1'b0 || req_ack_dm !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse: err=%b ack_dm=%b want 0 0", bus_err, req_ack_dm);
        end
    endtask

    task automatic test_ack_at_limit();
        int hi;
        bit seen;
        logic [31:0] e;
        hi = 0; seen = 1'b0;
        bus_lat = 6;
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h200;
        exp_i.push_back(32'h0000_1234);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (req_bus) hi++;
            if (req_ack_i) seen = 1'b1;
        end
        e = (exp_i.size() > 0) ? exp_i.pop_front() : 32'hFFFF_FFFF;
        total++;
        if (!seen || hi != 7 || bus_err !== 1'b0 || rd_i !== e) begin
            bad++;
            $display("FAIL ack_wins: ack=%0d req_bus cycles=%0d err=%b rd_i=%h want 1 7 0 %h",
                     seen, hi, bus_err, rd_i, e);
        end
        req_i = 1'b0;
        bus_lat = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int hi;
        bit seen;
        logic [31:0] e;
        bus_dead = 1'b1;
        @(negedge clk);
        req_dm = 1'b1; addr_dm = 32'h600; we_dm = 1'b0; size_dm = 2'b01;
        @(negedge clk);
        total++;
        if (req_bus !== 1'b1 || addr_bus !== 32'h600) begin
            bad++;
            $display("FAIL mid_issue: req_bus=%b addr=%h want 1 00000600", req_bus, addr_bus);
        end
        rst = 1'b1; req_dm = 1'b0;
        @(negedge clk);
        total++;
        if (req_bus !== 1'b0 || req_ack_dm !== 1'b0 || rd_i !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: req_bus=%b ack_dm=%b rd_i=%h want 0 0 00000000",
                     req_bus, req_ack_dm, rd_i);
        end
        rst = 1'b0; bus_dead = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ack_dm || req_ack_i || req_bus) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abandoned_access: activity after reset got 1 want 0");
        end
        // A fresh load after reset must still be served normally.
        bus_lat = 2; hi = 0; seen = 1'b0;
        req_dm = 1'b1; addr_dm = 32'h700; size_dm = 2'b10;
        exp_d.push_back(data_fn(32'h700));
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            hi++;
            if (req_ack_dm) seen = 1'b1;
        end
        e = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hFFFF_FFFF;
        total++;
        if (!seen || hi != 4 || rd_dm !== e) begin
            bad++;
            $display("FAIL post_reset_load: ack=%0d at cycle %0d rd_dm=%h want 1 4 %h",
                     seen, hi, rd_dm, e);
        end
        req_dm = 1'b0; bus_lat = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_instr();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
